input_sdim_packer: RTL and testbench

INPUT_SDIM_PACKER -- requirements
Module: input_sdim_packer

---
 rtl/input_sdim_packer.sv | 137 +++++++++++++
 tb/tb_input_sdim_packer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/input_sdim_packer.sv
// ---------------------------------------------------------------------------
// input_sdim_packer
//   Collects SDIM consecutive ELEM_WIDTH-bit elements from an AXI-Stream
//   element input and emits them as one packed beat. Element k of a beat sits
//   in bits [(k+1)*ELEM_WIDTH-1 : k*ELEM_WIDTH]; k=0 is the first accepted.
//   A block counter tracks position inside a BDIM-element block so that the
//   beat carrying block element BDIM-1 can be flagged with tlast.
//
// Optional feature:
//   INPUT_SDIM_PACKER_TLAST_EN  - when defined, adds the m_axis_input0_tlast
//                                 port and its output register.
//
// Ports:
//   ap_clk                - clock
//   ap_rst                - synchronous active-high reset
//   s_axis_elem_tdata     - input element
//   s_axis_elem_tvalid    - input element valid
//   s_axis_elem_tready    - input element ready (combinational)
//   m_axis_input0_tdata   - packed output beat, ELEM_WIDTH*SDIM bits
//   m_axis_input0_tvalid  - output beat valid
//   m_axis_input0_tlast   - last beat of block (only with the macro)
//   m_axis_input0_tready  - downstream ready
// ---------------------------------------------------------------------------
module input_sdim_packer #(
    parameter int ELEM_WIDTH = 8,
    parameter int SDIM       = 4,
    parameter int BDIM       = 16
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic [ELEM_WIDTH-1:0]      s_axis_elem_tdata,
    input  logic                       s_axis_elem_tvalid,
    output logic                       s_axis_elem_tready,
    output logic [ELEM_WIDTH*SDIM-1:0] m_axis_input0_tdata,
    output logic                       m_axis_input0_tvalid,
`ifdef INPUT_SDIM_PACKER_TLAST_EN
    output logic                       m_axis_input0_tlast,
`endif
    input  logic                       m_axis_input0_tready
);

    localparam int BEAT_W = ELEM_WIDTH * SDIM;
    // Counters keep at least one bit so SDIM=1 / BDIM=1 still elaborate.
    localparam int LANE_W = (SDIM > 1) ? $clog2(SDIM) : 1;
    localparam int BLK_W  = (BDIM > 1) ? $clog2(BDIM) : 1;
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(SDIM - 1);
    localparam logic [BLK_W-1:0]  BLK_MAX  = BLK_W'(BDIM - 1);

    generate
        if (SDIM < 1 || SDIM > 16) begin : g_bad_sdim
            $error("input_sdim_packer: SDIM must be in 1..16");
        end
        if (BDIM < SDIM || (BDIM % SDIM) != 0) begin : g_bad_bdim
            $error("input_sdim_packer: BDIM must be a multiple of SDIM");
        end
    endgenerate

    logic [LANE_W-1:0] r_lane;
    logic [BLK_W-1:0]  r_blk;
    logic [BEAT_W-1:0] r_collect;
    logic [BEAT_W-1:0] r_data;
    logic              r_valid;
`ifdef INPUT_SDIM_PACKER_TLAST_EN
    logic              r_last;
`endif

    logic              w_accept;
    logic              w_lane_last;
    logic              w_blk_last;
    logic              w_beat_done;
    logic [BEAT_W-1:0] w_beat;

    // The input may only advance when the output register is empty or is
    // draining this cycle, so a completed beat always has somewhere to go.
    assign s_axis_elem_tready = ~ap_rst & (~r_valid | m_axis_input0_tready);
    assign w_accept           = s_axis_elem_tvalid & s_axis_elem_tready;
    assign w_lane_last        = (r_lane == LANE_MAX);
    assign w_blk_last         = (r_blk == BLK_MAX);
    assign w_beat_done        = w_accept & w_lane_last;

    // Collect register with the incoming element merged into the current
    // lane. Feeding this straight into the output register lets the final
    // element of a beat land without an extra pipeline cycle.
    generate
        for (genvar k = 0; k < SDIM; k++) begin : g_lane
            localparam logic [LANE_W-1:0] LANE_IDX = LANE_W'(k);
            assign w_beat[k*ELEM_WIDTH +: ELEM_WIDTH] =
                (r_lane == LANE_IDX) ? s_axis_elem_tdata
                                     : r_collect[k*ELEM_WIDTH +: ELEM_WIDTH];
        end
    endgenerate

    // Input side: lane/block counters and the collect register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_lane    <= '0;
            r_blk     <= '0;
            r_collect <= '0;
        end else if (w_accept) begin
            r_collect <= w_beat;
            r_lane    <= w_lane_last ? '0 : r_lane + LANE_W'(1);
            r_blk     <= w_blk_last  ? '0 : r_blk + BLK_W'(1);
        end
    end

    // Output register. A load takes priority over a drain, which gives
    // back-to-back beats with no bubble when both happen on one edge.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_beat_done) begin
            r_data  <= w_beat;
            r_valid <= 1'b1;
        end else if (m_axis_input0_tready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef INPUT_SDIM_PACKER_TLAST_EN
    // BDIM is a multiple of SDIM, so block element BDIM-1 is always the
    // final lane of a beat and the flag can be captured at beat completion.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_last <= 1'b0;
        end else if (w_beat_done) begin
            r_last <= w_blk_last;
        end
    end

    assign m_axis_input0_tlast = r_last;
`endif

    assign m_axis_input0_tdata  = r_data;
    assign m_axis_input0_tvalid = r_valid;

endmodule

// File: tb/tb_input_sdim_packer.sv
module tb_input_sdim_packer;

    localparam int EW = 8;
    localparam int SD = 4;
    localparam int BD = 16;
    localparam int BW = EW * SD;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic [EW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [BW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
`ifdef INPUT_SDIM_PACKER_TLAST_EN
    logic          m_tlast;
`endif

    always #5 ap_clk = ~ap_clk;

    input_sdim_packer #(.ELEM_WIDTH(EW), .SDIM(SD), .BDIM(BD)) dut (
        .ap_clk               (ap_clk),
        .ap_rst               (ap_rst),
        .s_axis_elem_tdata    (s_tdata),
        .s_axis_elem_tvalid   (s_tvalid),
        .s_axis_elem_tready   (s_tready),
        .m_axis_input0_tdata  (m_tdata),
        .m_axis_input0_tvalid (m_tvalid),
`ifdef INPUT_SDIM_PACKER_TLAST_EN
        .m_axis_input0_tlast  (m_tlast),
`endif
        .m_axis_input0_tready (m_tready)
    );

    // Reference model: a list of accepted elements of the current word, a
    // running position inside the block, and the queue of beats the block
    // is expected to present downstream (in order).
    typedef struct {
        logic [BW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [EW-1:0] part[$];
    int            blk_pos  = 0;
    int            acc_cnt  = 0;
    int            beat_cnt = 0;
    int            checks   = 0;
    int            errors   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] pack(input int n);
        logic [BW-1:0] b = '0;
        for (int k = 0; k < n; k++) b = b | (BW'(part[k]) << (EW * k));
        return b;
    endfunction

    // One clock of stimulus: drive after the falling edge, check the model's
    // view of the outputs, then advance the model across the rising edge.
    task automatic step(input logic vin, input logic [EW-1:0] din, input logic rdy);
        logic  mv, mr, acc, drn;
        beat_t nb;
        @(negedge ap_clk);
        s_tvalid = vin;
        s_tdata  = din;
        m_tready = rdy;
        #1;
        mv = (exp_q.size() != 0);
        mr = !mv || rdy;
        chk("tready", 64'(s_tready), 64'(mr));
        chk("tvalid", 64'(m_tvalid), 64'(mv));
        if (mv) begin
            chk("tdata", 64'(m_tdata), 64'(exp_q[0].data));
`ifdef INPUT_SDIM_PACKER_TLAST_EN
            chk("tlast", 64'(m_tlast), 64'(exp_q[0].last));
`endif
        end
        acc = vin && mr;
        drn = mv && rdy;
        @(posedge ap_clk);
        if (drn) begin
            void'(exp_q.pop_front());
            beat_cnt++;
        end
        if (acc) begin
            part.push_back(din);
            acc_cnt++;
            if (part.size() == SD) begin
                nb.data = pack(SD);
                nb.last = (blk_pos == BD - 1);
                exp_q.push_back(nb);
                part.delete();
            end
            blk_pos = (blk_pos + 1) % BD;
        end
    endtask

    // One-cycle reset with an element offered, which must not be taken.
    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst   = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 8'hEE;
        m_tready = 1'b0;
        #1;
        chk("rst_tready", 64'(s_tready), 64'd0);
        @(posedge ap_clk);
        #1;
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_tdata), 64'd0);
`ifdef INPUT_SDIM_PACKER_TLAST_EN
        chk("rst_tlast", 64'(m_tlast), 64'd0);
`endif
        ap_rst   = 1'b0;
        s_tvalid = 1'b0;
        exp_q.delete();
        part.delete();
        blk_pos = 0;
    endtask

    initial begin
        int b0, a0, guard;

        do_reset();

        // Four elements on consecutive cycles; beat one cycle after the last.
        for (int i = 1; i <= 4; i++) step(1'b1, EW'(i), 1'b1);
        #1;
        chk("lat_tvalid", 64'(m_tvalid), 64'd1);
        chk("lat_tdata", 64'(m_tdata), 64'h04030201);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Backpressure: build a beat, stall downstream while offering more.
        for (int i = 0; i < 4; i++) step(1'b1, EW'(8'h20 + i), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h55, 1'b0);
        #1;
        chk("stall_tready", 64'(s_tready), 64'd0);
        chk("stall_tdata", 64'(m_tdata), 64'h23222120);
        step(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, EW'(8'h56 + i), 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Full block streamed without gaps, starting on a block boundary.
        do_reset();
        b0 = beat_cnt;
        for (int i = 0; i < 16; i++) step(1'b1, EW'(i), 1'b1);
        #1;
        chk("blk_last_tdata", 64'(m_tdata), 64'h0F0E0D0C);
`ifdef INPUT_SDIM_PACKER_TLAST_EN
        chk("blk_last_tlast", 64'(m_tlast), 64'd1);
`endif
        step(1'b0, '0, 1'b1);
        chk("blk_beats", 64'(beat_cnt - b0), 64'd4);

        // Reset mid-word and mid-block discards partial data and restarts
        // block counting.
        step(1'b1, 8'hAA, 1'b1);
        step(1'b1, 8'hBB, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, EW'(8'h11 + i), 1'b1);
        #1;
        chk("rst_mid_tdata", 64'(m_tdata), 64'h14131211);
`ifdef INPUT_SDIM_PACKER_TLAST_EN
        chk("rst_mid_tlast", 64'(m_tlast), 64'd0);
`endif
        for (int i = 0; i < 12; i++) step(1'b1, EW'(8'h15 + i), 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Random valid/ready at 50% for 1000 accepted elements.
        a0    = acc_cnt;
        guard = 0;
        while (acc_cnt - a0 < 1000 && guard < 20000) begin
            step(1'($urandom_range(0, 1)), EW'($urandom), 1'($urandom_range(0, 1)));
            guard++;
        end
        chk("rand_accepted", 64'(acc_cnt - a0), 64'd1000);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        #1;
        chk("rand_drained", 64'(m_tvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
